// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: button indices, the
// auto-repeat state encoding and small sizing helpers.
package btn_pkg;

    // Button positions inside btn_raw / held
    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_INC   = 2;
    localparam int BTN_DEC   = 3;
    localparam int NUM_BTN   = 4;

    // Per-button auto-repeat state
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_e;

    // Larger of two integers, used to size the shared repeat counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button bit: two-flop synchronizer, debounce filter and a registered
// single-cycle press pulse on each debounced 0->1 transition.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYC);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          s1_q;
    logic          s2_q;
    logic          stable_q;
    logic          stable_d;
    logic          press_q;
    logic          press_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Debounce decision: count consecutive disagreeing cycles, flip once the
    // disagreement has persisted for DEBOUNCE_CYC cycles
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
                cnt_d    = '0;
                // Only the rising edge of the debounced level is a command
                press_d  = s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchronizer and filter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            s1_q     <= raw;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign level = stable_q;
    assign press = press_q;

endmodule

// File: rtl/btn_cond.sv
// Button conditioner: four debounced buttons producing single-cycle command
// pulses, with optional auto-repeat while a button is held.
module btn_cond
    import btn_pkg::*;
#(
    parameter int         DEBOUNCE_CYC     = 1_000_000,
    parameter int         REPEAT_DELAY_CYC = 50_000_000,
    parameter int         REPEAT_RATE_CYC  = 12_500_000,
    parameter logic [3:0] REPEAT_MASK      = 4'b1100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    output logic       left,
    output logic       right,
    output logic       inc,
    output logic       dec,
    output logic [3:0] held
);

    // Repeat counter is shared between the delay and rate phases
    localparam int              RCW        = cnt_width(max_int(REPEAT_DELAY_CYC, REPEAT_RATE_CYC));
    localparam logic [RCW-1:0]  DELAY_LAST = RCW'(REPEAT_DELAY_CYC - 1);
    localparam logic [RCW-1:0]  RATE_LAST  = RCW'(REPEAT_RATE_CYC - 1);

    logic [NUM_BTN-1:0] level_w;
    logic [NUM_BTN-1:0] press_w;
    logic [NUM_BTN-1:0] rep_w;
    logic [NUM_BTN-1:0] pulse_w;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn

            btn_debounce #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC)
            ) u_debounce (
                .clk   (clk),
                .rst   (rst),
                .raw   (btn_raw[gi]),
                .level (level_w[gi]),
                .press (press_w[gi])
            );

            if (REPEAT_MASK[gi]) begin : g_rep
                rep_state_e     state_q;
                rep_state_e     state_d;
                logic [RCW-1:0] rcnt_q;
                logic [RCW-1:0] rcnt_d;
                logic           rep_q;
                logic           rep_d;

                // The FSM observes the registered press pulse one cycle after
                // the debounced level rose. Logically it entered DELAY with
                // rcnt=0 on that rising edge, so the IDLE branch performs the
                // first DELAY step directly; repeat timing stays anchored to
                // the press-pulse edge.

                // State register
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        state_q <= IDLE;
                        rcnt_q  <= '0;
                        rep_q   <= 1'b0;
                    end else begin
                        state_q <= state_d;
                        rcnt_q  <= rcnt_d;
                        rep_q   <= rep_d;
                    end
                end

                // Next-state and counter update
                always_comb begin
                    state_d = state_q;
                    rcnt_d  = rcnt_q;
                    case (state_q)
                        IDLE: begin
                            rcnt_d = '0;
                            if (press_w[gi]) begin
                                if (DELAY_LAST == '0) begin
                                    state_d = REPEAT;
                                end else begin
                                    state_d = DELAY;
                                    rcnt_d  = RCW'(1);
                                end
                            end
                        end
                        DELAY: begin
                            if (!level_w[gi]) begin
                                state_d = IDLE;
                                rcnt_d  = '0;
                            end else if (rcnt_q == DELAY_LAST) begin
                                state_d = REPEAT;
                                rcnt_d  = '0;
                            end else begin
                                rcnt_d = rcnt_q + RCW'(1);
                            end
                        end
                        REPEAT: begin
                            if (!level_w[gi]) begin
                                state_d = IDLE;
                                rcnt_d  = '0;
                            end else if (rcnt_q == RATE_LAST) begin
                                rcnt_d = '0;
                            end else begin
                                rcnt_d = rcnt_q + RCW'(1);
                            end
                        end
                        default: begin
                            state_d = IDLE;
                            rcnt_d  = '0;
                        end
                    endcase
                end

                // Repeat pulse request, registered by the state register
                always_comb begin
                    rep_d = 1'b0;
                    case (state_q)
                        IDLE:    rep_d = press_w[gi] && (DELAY_LAST == '0);
                        DELAY:   rep_d = level_w[gi] && (rcnt_q == DELAY_LAST);
                        REPEAT:  rep_d = level_w[gi] && (rcnt_q == RATE_LAST);
                        default: rep_d = 1'b0;
                    endcase
                end

                // A repeat pulse registered on the edge where the debounced
                // level fell is suppressed, so release never yields a pulse
                assign rep_w[gi] = rep_q & level_w[gi];
            end else begin : g_norep
                assign rep_w[gi] = 1'b0;
            end
        end
    endgenerate

    // Command pulse = press pulse OR repeat pulse (never coincident)
    assign pulse_w = press_w | rep_w;

    assign left  = pulse_w[BTN_LEFT];
    assign right = pulse_w[BTN_RIGHT];
    assign inc   = pulse_w[BTN_INC];
    assign dec   = pulse_w[BTN_DEC];
    assign held  = level_w;

endmodule

// File: tb/tb_btn_cond.sv
// Randomized and directed bench for btn_cond with a scoreboard: the driver
// pushes the expected per-edge outputs from a reference model, a monitor
// pops and compares after every clock edge.
module tb_btn_cond;

    localparam int         DEB  = 4;
    localparam int         RD   = 10;
    localparam int         RR   = 3;
    localparam logic [3:0] MASK = 4'b1100;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic       left, right, inc, dec;
    logic [3:0] held;

    always #5 clk = ~clk;

    btn_cond #(
        .DEBOUNCE_CYC     (DEB),
        .REPEAT_DELAY_CYC (RD),
        .REPEAT_RATE_CYC  (RR),
        .REPEAT_MASK      (MASK)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .left    (left),
        .right   (right),
        .inc     (inc),
        .dec     (dec),
        .held    (held)
    );

    typedef struct {
        int         edge_n;
        logic [3:0] held;
        logic [3:0] pulse;   // {dec, inc, right, left}
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pulses_seen = 0;

    // Reference model state, per button
    logic        m_s1[4];
    logic        m_s2[4];
    logic        m_stable[4];
    logic [31:0] hist[4];       // s2 seen before each edge, newest in bit 0
    int          since_flip[4]; // edges since last level change or reset
    int          rise_edge[4];  // edge of the current press, -1 if not held
    int          edge_n = 0;

    // Apply inputs for the next edge, predict outputs after it, wait for it
    task automatic step(input logic rst_v, input logic [3:0] raw_v);
        exp_t e;
        logic ok;
        logic new_stable;
        rst     = rst_v;
        btn_raw = raw_v;
        edge_n++;
        e.edge_n = edge_n;
        e.held   = '0;
        e.pulse  = '0;
        for (int b = 0; b < 4; b++) begin
            if (rst_v) begin
                m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_stable[b] = 1'b0;
                hist[b] = '0; since_flip[b] = 0; rise_edge[b] = -1;
            end else begin
                hist[b] = {hist[b][30:0], m_s2[b]};
                since_flip[b]++;
                new_stable = m_stable[b];
                // Level flips once the last DEB samples since the previous
                // change all disagree with it
                ok = (since_flip[b] >= DEB);
                for (int j = 0; j < DEB; j++)
                    if (hist[b][j] == m_stable[b]) ok = 1'b0;
                if (ok) begin
                    new_stable    = ~m_stable[b];
                    since_flip[b] = 0;
                end
                if (new_stable && !m_stable[b]) begin
                    rise_edge[b] = edge_n;
                    e.pulse[b]   = 1'b1;
                end
                if (!new_stable) rise_edge[b] = -1;
                if (MASK[b] && new_stable && rise_edge[b] >= 0 &&
                    (edge_n - rise_edge[b]) >= RD &&
                    ((edge_n - rise_edge[b] - RD) % RR) == 0)
                    e.pulse[b] = 1'b1;
                m_s2[b]     = m_s1[b];
                m_s1[b]     = raw_v[b];
                m_stable[b] = new_stable;
                e.held[b]   = new_stable;
            end
        end
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] raw_v, input int n);
        for (int i = 0; i < n; i++) step(1'b0, raw_v);
    endtask

    // Monitor: compare the DUT after each edge against the oldest prediction
    initial begin
        exp_t e;
        logic [3:0] got_p;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e     = exp_q.pop_front();
                got_p = {dec, inc, right, left};
                checks++;
                if (got_p != '0) pulses_seen++;
                if (got_p !== e.pulse || held !== e.held) begin
                    errors++;
                    $display("FAIL edge %0d outputs: got pulses=%b held=%b, expected pulses=%b held=%b",
                             e.edge_n, got_p, held, e.pulse, e.held);
                end
            end
        end
    end

    // Driver
    initial begin
        logic [3:0] raw_r;
        int         rst_left;
        rst     = 1'b1;
        btn_raw = '0;
        for (int b = 0; b < 4; b++) begin
            m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_stable[b] = 1'b0;
            hist[b] = '0; since_flip[b] = 0; rise_edge[b] = -1;
        end

        // Reset state
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0000);

        // Clean press on left
        hold(4'b0001, 8);
        hold(4'b0000, 12);

        // Bouncing right, then steady
        hold(4'b0010, 1); hold(4'b0000, 1);
        hold(4'b0010, 1); hold(4'b0000, 1);
        hold(4'b0010, 10);
        hold(4'b0000, 12);

        // Auto-repeat on inc
        hold(4'b0100, 30);
        hold(4'b0000, 15);

        // Left held long: no repeat
        hold(4'b0001, 40);
        hold(4'b0000, 12);

        // inc and dec together, repeating in lockstep
        hold(4'b1100, 25);
        hold(4'b0000, 12);

        // Reset while inc held, then continue holding
        hold(4'b0100, 17);
        step(1'b1, 4'b0100);
        step(1'b1, 4'b0100);
        hold(4'b0100, 25);
        hold(4'b0000, 12);

        // Random bouncing buttons with occasional resets
        raw_r    = '0;
        rst_left = 0;
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 13) == 0) raw_r[b] = ~raw_r[b];
            if (rst_left == 0 && $urandom_range(0, 599) == 0)
                rst_left = $urandom_range(1, 3);
            if (rst_left > 0) begin
                step(1'b1, raw_r);
                rst_left--;
            end else begin
                step(1'b0, raw_r);
            end
        end
        hold(4'b0000, 12);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        checks++;
        if (pulses_seen == 0) begin
            errors++;
            $display("FAIL activity: saw %0d pulse cycles, expected some", pulses_seen);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
